// File: rtl/ram_arbiter_ctrl.sv
// Round-robin arbiter that shares the single-port SPI-side RAM between NUM_REQ requesters.
// Each granted request becomes an address command, a data/read command, an optional read wait, and a one-cycle response.
module ram_arbiter_ctrl #(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_SIZE = 8,
    parameter int TIMEOUT   = 8,
    localparam int IDW      = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_we,
    input  logic [NUM_REQ*ADDR_SIZE-1:0] req_addr,
    input  logic [NUM_REQ*ADDR_SIZE-1:0] req_wdata,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [ADDR_SIZE-1:0]         rsp_rdata,
    output logic                         rsp_err,
    output logic [ADDR_SIZE+1:0]         ram_din,
    output logic                         ram_rx_valid,
    input  logic [ADDR_SIZE-1:0]         ram_dout,
    input  logic                         ram_tx_valid,
    output logic                         busy,
    output logic [IDW-1:0]               grant_id
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, WAIT_RD, RESP} state_t;

    state_t                state, next_state;
    logic [IDW-1:0]        rr_ptr;
    logic [IDW-1:0]        grant_idx;
    logic [IDW-1:0]        cand;
    logic                  any_valid;
    logic                  found;
    logic                  sel_we;
    logic [ADDR_SIZE-1:0]  sel_addr;
    logic [ADDR_SIZE-1:0]  sel_wdata;
    logic                  lat_we;
    logic [ADDR_SIZE-1:0]  lat_addr;
    logic [ADDR_SIZE-1:0]  lat_wdata;
    logic [ADDR_SIZE-1:0]  rdata;
    logic                  err;
    logic [CW-1:0]         tcnt;

    // Scan starts just past the last winner, so the last winner gets the lowest priority.
    always_comb begin
        any_valid = |req_valid;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*ADDR_SIZE +: ADDR_SIZE];
                sel_wdata = req_wdata[i*ADDR_SIZE +: ADDR_SIZE];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_valid) next_state = ADDR;
            ADDR:    next_state = DATA;
            DATA:    next_state = lat_we ? RESP : WAIT_RD;
            WAIT_RD: if (ram_tx_valid || tcnt == TMAX) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The address is re-sent on every transaction because the RAM's address registers are shared.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= IDW'(NUM_REQ - 1);
            grant_id  <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata     <= '0;
            err       <= 1'b0;
            tcnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        lat_we    <= sel_we;
                        lat_addr  <= sel_addr;
                        lat_wdata <= sel_wdata;
                        grant_id  <= grant_idx;
                        rr_ptr    <= grant_idx;
                        rdata     <= '0;
                        err       <= 1'b0;
                    end
                end
                DATA: tcnt <= '0;
                WAIT_RD: begin
                    if (ram_tx_valid) begin
                        rdata <= ram_dout;
                        err   <= 1'b0;
                    end else if (tcnt == TMAX) begin
                        rdata <= '0;
                        err   <= 1'b1;
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready    = '0;
        rsp_valid    = '0;
        rsp_rdata    = '0;
        rsp_err      = 1'b0;
        ram_din      = '0;
        ram_rx_valid = 1'b0;
        case (state)
            IDLE: if (any_valid && !rst) req_ready[grant_idx] = 1'b1;
            ADDR: begin
                ram_rx_valid = 1'b1;
                ram_din      = {(lat_we ? 2'b00 : 2'b10), lat_addr};
            end
            DATA: begin
                ram_rx_valid = 1'b1;
                ram_din      = lat_we ? {2'b01, lat_wdata} : {2'b11, {ADDR_SIZE{1'b0}}};
            end
            RESP: begin
                rsp_valid[grant_id] = 1'b1;
                rsp_rdata           = rdata;
                rsp_err             = err;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/ram_arbiter_ctrl.md
Name: ram_arbiter_ctrl

Overview:
Round-robin arbiter and command sequencer that shares the single-port SPI-side RAM between NUM_REQ requesters. Each requester issues one atomic read or write request (address plus data). The controller grants one requester, drives the RAM's two-command sequence on its din/rx_valid port, and collects the read data. It then returns a one-cycle response to the granted requester. It sits between the requester fabric and the RAM, in place of a direct SPI-to-RAM connection.

Parameters:
NUM_REQ, 2, number of requesters; legal range 2..8
ADDR_SIZE, 8, RAM address and data width; RAM command word is ADDR_SIZE+2 bits
TIMEOUT, 8, maximum WAIT_RD cycles to wait for ram_tx_valid before an error response
IDW, $clog2(NUM_REQ), width of grant_id (derived, not overridable)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester request pending
req_we  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_SIZE  packed addresses; requester i occupies slice [i*ADDR_SIZE +: ADDR_SIZE]
req_wdata  in  NUM_REQ*ADDR_SIZE  packed write data, same slicing
req_ready  out  NUM_REQ  one-hot grant/accept strobe
rsp_valid  out  NUM_REQ  one-hot one-cycle response strobe
rsp_rdata  out  ADDR_SIZE  read data (shared; qualified by rsp_valid)
rsp_err  out  1  read timeout flag (qualified by rsp_valid)
ram_din  out  ADDR_SIZE+2  RAM command word {op[1:0], payload}
ram_rx_valid  out  1  RAM command strobe
ram_dout  in  ADDR_SIZE  RAM read data
ram_tx_valid  in  1  RAM read data valid
busy  out  1  1 whenever state != IDLE
grant_id  out  IDW  index of the current/last granted requester

Behaviour:
- Reset (synchronous, rst=1 at the edge) forces the following values:
  - state=IDLE; rr pointer=NUM_REQ-1, so requester 0 has first priority.
  - All outputs 0: req_ready, rsp_valid, rsp_rdata, rsp_err, ram_din, ram_rx_valid, busy, grant_id.
  - An in-flight transaction is dropped silently: no rsp_valid is issued, and the RAM may hold partial address state.
- FSM states: IDLE, ADDR, DATA, WAIT_RD, RESP.
- IDLE:
  - If any req_valid is set, grant g = first set bit scanning pointer+1, pointer+2, ... modulo NUM_REQ.
  - req_ready[g]=1 combinationally in this cycle only.
  - On the edge: latch we/addr/wdata of g, grant_id<=g, pointer<=g, go to ADDR.
  - If no req_valid is set, stay in IDLE.
- Request rules:
  - Requesters must hold req_valid and payload stable until req_ready.
  - Deasserting req_valid before the grant is allowed and has no effect.
- ADDR: ram_rx_valid=1, ram_din={we?2'b00:2'b10, addr}. Next state is DATA.
- DATA: ram_rx_valid=1.
  - Write: ram_din={2'b01, wdata}, then go to RESP.
  - Read: ram_din={2'b11, {ADDR_SIZE{1'b0}}}, then go to WAIT_RD with the timeout counter cleared.
- WAIT_RD: ram_rx_valid=0.
  - If ram_tx_valid=1: latch ram_dout into rdata, clear err, go to RESP.
  - Else the counter increments. When the counter reaches TIMEOUT-1 with no tx_valid: rdata<=0, err<=1, go to RESP.
- RESP: rsp_valid[grant_id]=1 for exactly one cycle, with rsp_rdata=rdata and rsp_err=err. Writes return rdata=0, err=0. Next state is IDLE.
- Output timing:
  - ram_din, ram_rx_valid, rsp_* and busy are Moore outputs (from state and latched regs only).
  - ram_din=0 and ram_rx_valid=0 outside ADDR/DATA.
- Latency, with grant in cycle T:
  - Write: commands in T+1 and T+2, rsp_valid in T+3; next grant no earlier than T+4.
  - Read: commands in T+1 and T+2, ram_tx_valid expected in T+3, rsp_valid in T+4; next grant no earlier than T+5.
- The address command is always re-sent. The RAM's address registers are shared and unreset, so no address caching is permitted.
- ram_tx_valid is sticky in the RAM and is only sampled in WAIT_RD.
- Fairness: with all requesters continuously valid, grants rotate strictly. No requester waits more than NUM_REQ-1 transactions.

Test Plan:
- Write: rst, then req 0 writes addr 0x12 data 0xA5 → ram_din=0x012 at T+1 and 0x1A5 at T+2 with ram_rx_valid; rsp_valid=2'b01 at T+3 with rdata 0x00, err 0.
- Read: req 0 reads addr 0x12 after the write above → ram_din=0x212 then 0x300; rsp_valid[0] at T+4 with rsp_rdata=0xA5, err 0.
- Arbitration: req 0 (write 0x01←0x11) and req 1 (write 0x02←0x22) held continuously → grant_id sequence 0,1,0,1; readback gives mem[0x01]=0x11 and mem[0x02]=0x22.
- Timeout: TIMEOUT=4, RAM model forces ram_tx_valid=0, read addr 0x40 → rsp_err=1 and rsp_rdata=0x00 after 4 WAIT_RD cycles; busy falls the following cycle.
- Reset mid-operation: assert rst during DATA of a write → next cycle ram_rx_valid=0, busy=0 and no rsp_valid. With both requesters then valid, requester 0 is granted first.
- Cross-requester coherence: req 1 writes 0x7F←0x3C, then req 0 reads 0x7F back-to-back → rsp_rdata=0x3C on rsp_valid[0].
